// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Debounces a push button and uses it to toggle a three-stage reset
//   release. Stages come out of reset in order 0, 1, 2, each STAGE_DELAY
//   clocks apart. A second press aborts the release or, once running,
//   re-asserts every stage reset. While running, an error from any stage
//   that is already out of reset blinks the LED.
//
// Ports
//   osc_50       in   1  system clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   push_button  in   1  raw asynchronous button level
//   error        in   3  per-stage error flags (bit i = stage i)
//   sys_reset    out  3  active-high reset to each stage, registered
//   led          out  1  status LED, registered
//   busy         out  1  high while a staged release is in progress
//
// state   | meaning
// --------+------------------------------------------------------------
// HELD    | all stages in reset, LED on, waiting for a button toggle
// RELEASE | releasing stages 0..2 one per STAGE_DELAY clocks, busy high
// RUN     | all stages out of reset, LED blinks on an effective error

module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STAGE_DELAY     = 1024,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic       osc_50,
    input  logic       reset_n,
    input  logic       push_button,
    input  logic [2:0] error,
    output logic [2:0] sys_reset,
    output logic       led,
    output logic       busy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_DELAY - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_HELD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Button synchronizer and debouncer
    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          toggle_q, toggle_d;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        toggle_d  = 1'b0;
        if (sync2_q == deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_d     = sync2_q;
            deb_cnt_d = '0;
            // only an accepted press (0->1) produces a toggle
            toggle_d  = sync2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge osc_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            toggle_q  <= 1'b0;
        end else begin
            sync1_q   <= push_button;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            toggle_q  <= toggle_d;
        end
    end

    // Sequencing FSM
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [SW-1:0] dly_q, dly_d;
    logic [2:0]    sys_reset_q, sys_reset_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          eff_err;

    // stages still held in reset cannot raise a meaningful error
    assign eff_err = |(error & ~sys_reset_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dly_d       = dly_q;
        sys_reset_d = sys_reset_q;
        led_d       = led_q;
        busy_d      = busy_q;
        blink_cnt_d = '0;
        phase_d     = 1'b0;

        case (state_q)
            ST_HELD: begin
                sys_reset_d = 3'b111;
                led_d       = 1'b1;
                busy_d      = 1'b0;
                idx_d       = 2'd0;
                dly_d       = '0;
                if (toggle_q) begin
                    state_d = ST_RELEASE;
                    busy_d  = 1'b1;
                end
            end

            ST_RELEASE: begin
                led_d  = 1'b1;
                busy_d = 1'b1;
                if (toggle_q) begin
                    state_d     = ST_HELD;
                    sys_reset_d = 3'b111;
                    busy_d      = 1'b0;
                    idx_d       = 2'd0;
                    dly_d       = '0;
                end else if (dly_q == STAGE_LAST) begin
                    dly_d       = '0;
                    sys_reset_d = sys_reset_q & ~(3'b001 << idx_q);
                    if (idx_q == 2'd2) begin
                        // last stage released: running from this same edge
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                        led_d   = 1'b0;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    dly_d = dly_q + SW'(1);
                end
            end

            ST_RUN: begin
                busy_d      = 1'b0;
                sys_reset_d = 3'b000;
                if (toggle_q) begin
                    state_d     = ST_HELD;
                    sys_reset_d = 3'b111;
                    led_d       = 1'b1;
                end else if (eff_err) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                        phase_d     = phase_q;
                    end
                    led_d = phase_d;
                end else begin
                    led_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_HELD;
                sys_reset_d = 3'b111;
                led_d       = 1'b1;
                busy_d      = 1'b0;
                idx_d       = 2'd0;
                dly_d       = '0;
            end
        endcase
    end

    always_ff @(posedge osc_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HELD;
            idx_q       <= 2'd0;
            dly_q       <= '0;
            sys_reset_q <= 3'b111;
            led_q       <= 1'b1;
            busy_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dly_q       <= dly_d;
            sys_reset_q <= sys_reset_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign sys_reset = sys_reset_q;
    assign led       = led_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with DEBOUNCE_CYCLES=4, STAGE_DELAY=3,
// BLINK_HALF=5. Each stimulus step queues the {sys_reset, led, busy}
// value expected after the next clock edge (or right after an
// asynchronous reset assertion); the monitor pops and compares.

module tb_reset_sequencer;

   logic       osc_50 = 1'b0;
   logic       reset_n;
   logic       push_button;
   logic [2:0] error;
   logic [2:0] sys_reset;
   logic       led;
   logic       busy;

   typedef struct {
      logic [4:0] exp;
      string      name;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  n_steps  = 0;

   reset_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .STAGE_DELAY    (3),
      .BLINK_HALF     (5)
   ) dut (
      .osc_50     (osc_50),
      .reset_n    (reset_n),
      .push_button(push_button),
      .error      (error),
      .sys_reset  (sys_reset),
      .led        (led),
      .busy       (busy)
   );

   always #5 osc_50 = ~osc_50;

   // Monitor: every clock edge and every reset assertion presents an output
   initial begin
      sb_t        e;
      logic [4:0] act;
      forever begin
         @(posedge osc_50 or negedge reset_n);
         #1;
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {sys_reset, led, busy};
            n_checks++;
            if (act !== e.exp) begin
               n_fail++;
               $display("FAIL %s: got sys_reset=%b led=%b busy=%b, expected sys_reset=%b led=%b busy=%b",
                        e.name, act[4:2], act[1], act[0], e.exp[4:2], e.exp[1], e.exp[0]);
            end
         end
      end
   end

   task automatic step(input logic rst, input logic pb, input logic [2:0] err,
                       input logic [4:0] exp, input string nm);
      sb_t e;
      e.exp  = exp;
      e.name = nm;
      sb_q.push_back(e);
      n_steps++;
      reset_n     = rst;
      push_button = pb;
      error       = err;
      @(negedge osc_50);
   endtask

   task automatic run(input int n, input logic rst, input logic pb, input logic [2:0] err,
                      input logic [4:0] exp, input string nm);
      for (int i = 0; i < n; i++) step(rst, pb, err, exp, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      push_button = 1'b0;
      error       = 3'b000;
      repeat (2) @(negedge osc_50);

      run(3, 0, 0, 3'b000, 5'b11110, "reset_state");

      // press for 10 cycles: toggle after sync + debounce, staged release
      run(6, 1, 1, 3'b000, 5'b11110, "press_debouncing");
      run(3, 1, 1, 3'b000, 5'b11111, "release_start");
      run(1, 1, 1, 3'b000, 5'b11011, "bit0_released");
      run(2, 1, 0, 3'b000, 5'b11011, "bit0_released");
      run(3, 1, 0, 3'b000, 5'b10011, "bit1_released");
      run(4, 1, 0, 3'b000, 5'b00000, "run_idle");

      // blink on stage-1 error: 5 low, 5 high, repeating
      run(4, 1, 0, 3'b010, 5'b00000, "blink_low1");
      run(5, 1, 0, 3'b010, 5'b00010, "blink_high1");
      run(5, 1, 0, 3'b010, 5'b00000, "blink_low2");
      run(1, 1, 0, 3'b010, 5'b00010, "blink_high2");
      run(3, 1, 0, 3'b000, 5'b00000, "error_cleared");

      // blink again, then asynchronous reset mid-blink with button held
      run(4, 1, 0, 3'b010, 5'b00000, "blink_low3");
      run(3, 1, 0, 3'b010, 5'b00010, "blink_high3");
      step(0, 1, 3'b100, 5'b11110, "async_reset_midblink");
      run(2, 0, 1, 3'b100, 5'b11110, "reset_held");
      run(6, 1, 1, 3'b100, 5'b11110, "held_button_after_reset");
      run(2, 1, 1, 3'b100, 5'b11111, "release_after_reset");
      run(1, 1, 0, 3'b100, 5'b11111, "release_after_reset");
      run(3, 1, 0, 3'b100, 5'b11011, "bit2_err_masked_a");
      run(3, 1, 0, 3'b100, 5'b10011, "bit2_err_masked_b");
      run(5, 1, 0, 3'b100, 5'b00000, "run_err_blink_low");
      run(1, 1, 0, 3'b100, 5'b00010, "run_err_blink_high");

      // press while running: back to HELD
      run(4, 1, 1, 3'b100, 5'b00010, "run_press_blink_high");
      run(2, 1, 1, 3'b100, 5'b00000, "run_press_blink_low");
      run(1, 1, 1, 3'b100, 5'b11110, "toggle_in_run");
      run(7, 1, 0, 3'b000, 5'b11110, "held_after_run");

      // 3-cycle glitch must not toggle
      run(3, 1, 1, 3'b000, 5'b11110, "glitch");
      run(7, 1, 0, 3'b000, 5'b11110, "glitch_no_toggle");

      // second press lands during RELEASE after bits 0 and 1 cleared
      run(4, 1, 1, 3'b000, 5'b11110, "abort_press1");
      run(2, 1, 0, 3'b000, 5'b11110, "abort_press1");
      run(2, 1, 0, 3'b000, 5'b11111, "abort_release");
      run(1, 1, 1, 3'b000, 5'b11111, "abort_release");
      run(3, 1, 1, 3'b000, 5'b11011, "abort_bit0");
      run(2, 1, 0, 3'b000, 5'b10011, "abort_bit1");
      run(2, 1, 0, 3'b000, 5'b11110, "abort_to_held");
      run(8, 1, 0, 3'b000, 5'b11110, "held_after_abort");

      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard: %0d expectations never compared, expected 0", sb_q.size());
      end
      if (n_checks < n_steps) begin
         n_fail++;
         $display("FAIL check_count: got %0d checks, expected %0d", n_checks, n_steps);
      end
      if (sys_reset !== 3'b111) begin
         n_fail++;
         $display("FAIL final_sys_reset: got %b, expected 111", sys_reset);
      end
      if (led !== 1'b1) begin
         n_fail++;
         $display("FAIL final_led: got %b, expected 1", led);
      end
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL final_busy: got %b, expected 0", busy);
      end
      if (n_fail != 0) begin
         $display("FAIL summary: %0d failures, expected 0", n_fail);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
